shift_count_register: RTL and testbench
=======================================

# shift_count_register

Parametrised successor to the basic load/count/shift register. Adds three things the basic register does not have: multi-bit shifts and rotates executed serially one bit per cycle under a start/busy/done handshake, carry/borrow capture, and a zero flag. It sits in the datapath wherever a general register needs shift-by-N without a barrel shifter, e.g. as the operand register behind the ALU.

## Interface
- DATA_WIDTH, 16, register width in bits (≥ 2)
- SHAMT_WIDTH, 4, width of the shift-amount input; shift amounts 0 .. 2^SHAMT_WIDTH−1 are all legal, including amounts ≥ DATA_WIDTH
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, synchronous and active-high
- cl  in  1  clear the register to 0; also aborts a shift in progress
- ld  in  1  load `in` into the register
- in  in  DATA_WIDTH  load data
- inc  in  1  increment by 1, modulo 2^DATA_WIDTH
- dec  in  1  decrement by 1, modulo 2^DATA_WIDTH
- start  in  1  begin a shift operation
- op  in  3  shift mode: 0 SHL, 1 SHR, 2 SAR, 3 ROL, 4 ROR, 5–7 reserved
- amt  in  SHAMT_WIDTH  number of single-bit steps
- il  in  1  fill bit for the LSB on SHL
- ir  in  1  fill bit for the MSB on SHR
- out  out  DATA_WIDTH  register contents
- carry  out  1  registered carry/borrow/last-shifted-out bit
- zero  out  1  combinational, equals (out == 0)
- busy  out  1  registered; high while a shift is executing
- done  out  1  registered; one-cycle pulse when a shift completes

## Operation
- Reset: out=0, carry=0, busy=0, done=0, FSM in IDLE. zero therefore reads 1.
- FSM states: IDLE and SHIFT. The internal step counter is SHAMT_WIDTH bits wide.
- In IDLE, commands have fixed priority: cl > ld > start > inc > dec. Exactly one command executes per cycle.
  - cl: out=0, carry=0.
  - ld: out=in, carry=0.
  - inc: out=out+1; carry = carry-out (1 only when out was all-ones).
  - dec: out=out−1; carry = borrow (1 only when out was 0).
  - start with amt≥1 and op in 0–4: latch op, amt, il, ir; counter=amt; go to SHIFT; busy=1.
  - start with amt=0, or op in 5–7: out and carry unchanged; stay in IDLE; done pulses next cycle.
- In SHIFT, each edge performs one step, decrements the counter, and sets carry to the bit shifted or rotated out:
  - SHL: {out[W−2:0], il}
  - SHR: {ir, out[W−1:1]}
  - SAR: {out[W−1], out[W−1:1]}
  - ROL: {out[W−2:0], out[W−1]}
  - ROR: {out[0], out[W−1:1]}
- The step that brings the counter to 0 returns the FSM to IDLE, clears busy, and sets done for one cycle.
- In SHIFT, cl aborts the shift: out=0, carry=0, return to IDLE, busy=0, no done pulse. ld, inc, dec and start are ignored during SHIFT.
- Shift amounts larger than DATA_WIDTH simply perform more steps. Example: SHL by 20 on a 16-bit register gives all-il fill, and carry equals the final bit shifted out.
- done is cleared on every cycle in which it was not just set.

## Timing
- cl, ld, inc and dec: result visible on out and carry the cycle after the command is sampled (one-cycle latency).
- start sampled in cycle T with amt=N≥1:
  - busy is high in cycles T+1 .. T+N.
  - Intermediate values appear on out after each edge.
  - In cycle T+N+1: final out and carry are visible, busy=0, done=1.
  - A new command may be sampled in cycle T+N+1.
- start with amt=0 or a reserved op in cycle T: done=1 in cycle T+1; busy never rises.
- rst has priority over every command, including during SHIFT. It takes effect at the next edge and forces all reset values.
- zero is combinational from out and adds no latency.

## Test plan
- Reset: assert rst for 2 cycles mid-activity → out=0x0000, carry=0, busy=0, done=0, zero=1.
- ld 0xA5F0, then start op=SHL amt=4 il=1 → busy high for 4 cycles, then out=0x5F0F, carry=0, done pulses for exactly 1 cycle.
- ld 0x8001, start op=SAR amt=3 → out=0xF000, carry=0; then start op=ROR amt=1 on 0x0001 → out=0x8000, carry=1.
- ld 0xFFFF, inc → out=0x0000, carry=1, zero=1; then dec → out=0xFFFF, carry=1, zero=0.
- start op=SHL amt=8 on 0x1234, assert cl on the 3rd busy cycle → out=0x0000 the next cycle, busy=0, no done pulse; ld, inc and start pulses during busy are ignored.
- start with amt=0, and separately with op=6, on 0x00FF → out stays 0x00FF, busy stays 0, done=1 the next cycle. Simultaneous cl+ld+start in IDLE → out=0.

Source files
------------

// File: rtl/shift_count_register.sv
// General-purpose register with load/clear/increment/decrement and serial
// multi-bit shift/rotate under a start/busy/done handshake.
module shift_count_register #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SHAMT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cl,
    input  logic                   ld,
    input  logic [DATA_WIDTH-1:0]  in,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [SHAMT_WIDTH-1:0] amt,
    input  logic                   il,
    input  logic                   ir,
    output logic [DATA_WIDTH-1:0]  out,
    output logic                   carry,
    output logic                   zero,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    typedef enum logic [2:0] {
        OP_SHL = 3'd0,
        OP_SHR = 3'd1,
        OP_SAR = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    localparam logic [DATA_WIDTH:0]    DATA_ONE = (DATA_WIDTH + 1)'(1);
    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = SHAMT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   carry_q, carry_d;
    logic                   done_q, done_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    shift_op_e              op_q, op_d;
    logic                   il_q, il_d;
    logic                   ir_q, ir_d;

    logic [DATA_WIDTH:0]    inc_sum;
    logic [DATA_WIDTH:0]    dec_diff;
    logic [DATA_WIDTH-1:0]  step_data;
    logic                   step_carry;
    logic                   start_ok;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_SHL;
            il_q    <= 1'b0;
            ir_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            il_q    <= il_d;
            ir_q    <= ir_d;
        end
    end

    // Extra MSB of the widened sum/difference is the carry-out/borrow.
    always_comb begin
        inc_sum  = {1'b0, data_q} + DATA_ONE;
        dec_diff = {1'b0, data_q} - DATA_ONE;
        start_ok = (amt != '0) && (op <= 3'd4);
    end

    // One single-bit step of the latched shift operation
    always_comb begin
        step_data  = data_q;
        step_carry = carry_q;
        case (op_q)
            OP_SHL: begin
                step_data  = {data_q[DATA_WIDTH-2:0], il_q};
                step_carry = data_q[DATA_WIDTH-1];
            end
            OP_SHR: begin
                step_data  = {ir_q, data_q[DATA_WIDTH-1:1]};
                step_carry = data_q[0];
            end
            OP_SAR: begin
                step_data  = {data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]};
                step_carry = data_q[0];
            end
            OP_ROL: begin
                step_data  = {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
                step_carry = data_q[DATA_WIDTH-1];
            end
            OP_ROR: begin
                step_data  = {data_q[0], data_q[DATA_WIDTH-1:1]};
                step_carry = data_q[0];
            end
            default: ;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        op_d    = op_q;
        il_d    = il_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (cl) begin
                    data_d  = '0;
                    carry_d = 1'b0;
                end else if (ld) begin
                    data_d  = in;
                    carry_d = 1'b0;
                end else if (start) begin
                    if (start_ok) begin
                        state_d = SHIFT;
                        cnt_d   = amt;
                        op_d    = shift_op_e'(op);
                        il_d    = il;
                        ir_d    = ir;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (inc) begin
                    data_d  = inc_sum[DATA_WIDTH-1:0];
                    carry_d = inc_sum[DATA_WIDTH];
                end else if (dec) begin
                    data_d  = dec_diff[DATA_WIDTH-1:0];
                    carry_d = dec_diff[DATA_WIDTH];
                end
            end
            SHIFT: begin
                if (cl) begin
                    state_d = IDLE;
                    data_d  = '0;
                    carry_d = 1'b0;
                end else begin
                    data_d  = step_data;
                    carry_d = step_carry;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        out   = data_q;
        carry = carry_q;
        done  = done_q;
        busy  = (state_q == SHIFT);
        zero  = (data_q == '0);
    end

endmodule

// File: tb/tb_shift_count_register.sv
// Scoreboard bench for shift_count_register: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_shift_count_register;

    logic        clk;
    logic        rst;
    logic        cl;
    logic        ld;
    logic [15:0] in;
    logic        inc;
    logic        dec;
    logic        start;
    logic [2:0]  op;
    logic [3:0]  amt;
    logic        il;
    logic        ir;
    logic [15:0] out;
    logic        carry;
    logic        zero;
    logic        busy;
    logic        done;

    typedef struct {
        int unsigned cyc;
        logic [15:0] out;
        logic        carry;
        logic        busy;
        logic        done;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_dones = 0;
    int          act_dones = 0;

    shift_count_register #(
        .DATA_WIDTH (16),
        .SHAMT_WIDTH(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cl   (cl),
        .ld   (ld),
        .in   (in),
        .inc  (inc),
        .dec  (dec),
        .start(start),
        .op   (op),
        .amt  (amt),
        .il   (il),
        .ir   (ir),
        .out  (out),
        .carry(carry),
        .zero (zero),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_field(input string name, input string field,
                               input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h (cycle %0d)", name, field, act, req, cyc);
        end
    endtask

    // Monitor: compares every expectation stamped for the current cycle
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) act_dones++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s.stale: checked at cycle %0d, expected at cycle %0d", e.name, cyc, e.cyc);
            end else begin
                check_field(e.name, "out",   out,           e.out);
                check_field(e.name, "carry", {15'b0, carry}, {15'b0, e.carry});
                check_field(e.name, "zero",  {15'b0, zero},  {15'b0, (e.out == 16'h0000)});
                check_field(e.name, "busy",  {15'b0, busy},  {15'b0, e.busy});
                check_field(e.name, "done",  {15'b0, done},  {15'b0, e.done});
            end
        end
    end

    task automatic push_exp(input int unsigned k, input logic [15:0] o, input logic c,
                            input logic b, input logic d, input string name);
        exp_t e;
        int   idx;
        e.cyc   = cyc + k;
        e.out   = o;
        e.carry = c;
        e.busy  = b;
        e.done  = d;
        e.name  = name;
        if (d) exp_dones++;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic clr_in();
        cl = 0; ld = 0; in = '0; inc = 0; dec = 0;
        start = 0; op = '0; amt = '0; il = 0; ir = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    initial begin
        clr_in();
        rst = 1;
        tick();
        tick();
        rst = 0;
        push_exp(0, 16'h0000, 0, 0, 0, "rst_init");

        // Reset asserted for two cycles while a shift is running
        ld = 1; in = 16'h00AA;
        push_exp(1, 16'h00AA, 0, 0, 0, "ld_00aa");
        tick();
        start = 1; op = 3'd0; amt = 4'd5;
        push_exp(1, 16'h00AA, 0, 1, 0, "rstshl_b1");
        push_exp(2, 16'h0154, 0, 1, 0, "rstshl_b2");
        tick();
        tick();
        rst = 1;
        push_exp(1, 16'h0000, 0, 0, 0, "rst_mid1");
        tick();
        push_exp(1, 16'h0000, 0, 0, 0, "rst_mid2");
        tick();
        rst = 0;
        push_exp(1, 16'h0000, 0, 0, 0, "rst_release");
        tick();

        // SHL by 4 with il=1
        ld = 1; in = 16'hA5F0;
        push_exp(1, 16'hA5F0, 0, 0, 0, "ld_a5f0");
        tick();
        start = 1; op = 3'd0; amt = 4'd4; il = 1;
        push_exp(1, 16'hA5F0, 0, 1, 0, "shl4_s0");
        push_exp(2, 16'h4BE1, 1, 1, 0, "shl4_s1");
        push_exp(3, 16'h97C3, 0, 1, 0, "shl4_s2");
        push_exp(4, 16'h2F87, 1, 1, 0, "shl4_s3");
        push_exp(5, 16'h5F0F, 0, 0, 1, "shl4_done");
        push_exp(6, 16'h5F0F, 0, 0, 0, "shl4_after");
        repeat (7) tick();

        // SAR by 3, then a new load in the done cycle, then ROR by 1
        ld = 1; in = 16'h8001;
        push_exp(1, 16'h8001, 0, 0, 0, "ld_8001");
        tick();
        start = 1; op = 3'd2; amt = 4'd3;
        push_exp(1, 16'h8001, 0, 1, 0, "sar_s0");
        push_exp(2, 16'hC000, 1, 1, 0, "sar_s1");
        push_exp(3, 16'hE000, 0, 1, 0, "sar_s2");
        push_exp(4, 16'hF000, 0, 0, 1, "sar_done");
        repeat (4) tick();
        ld = 1; in = 16'h0001;
        push_exp(1, 16'h0001, 0, 0, 0, "ld_in_done_cycle");
        tick();
        start = 1; op = 3'd4; amt = 4'd1;
        push_exp(1, 16'h0001, 0, 1, 0, "ror_s0");
        push_exp(2, 16'h8000, 1, 0, 1, "ror_done");
        push_exp(3, 16'h8000, 1, 0, 0, "ror_after");
        repeat (3) tick();

        // Increment / decrement wrap with carry and borrow
        ld = 1; in = 16'hFFFF;
        push_exp(1, 16'hFFFF, 0, 0, 0, "ld_ffff");
        tick();
        inc = 1;
        push_exp(1, 16'h0000, 1, 0, 0, "inc_wrap");
        tick();
        dec = 1;
        push_exp(1, 16'hFFFF, 1, 0, 0, "dec_wrap");
        tick();
        dec = 1;
        push_exp(1, 16'hFFFE, 0, 0, 0, "dec_plain");
        tick();
        inc = 1;
        push_exp(1, 16'hFFFF, 0, 0, 0, "inc_plain");
        tick();
        ld = 1; in = 16'h0010;
        push_exp(1, 16'h0010, 0, 0, 0, "ld_0010");
        tick();
        inc = 1; dec = 1;
        push_exp(1, 16'h0011, 0, 0, 0, "inc_over_dec");
        tick();

        // Abort with cl on the 3rd busy cycle; ld/inc/start ignored while busy
        ld = 1; in = 16'h1234;
        push_exp(1, 16'h1234, 0, 0, 0, "ld_1234");
        tick();
        start = 1; op = 3'd0; amt = 4'd8;
        push_exp(1, 16'h1234, 0, 1, 0, "abort_b1");
        tick();
        ld = 1; in = 16'hFFFF;
        push_exp(1, 16'h2468, 0, 1, 0, "ignore_ld");
        tick();
        inc = 1; start = 1; op = 3'd1; amt = 4'd1;
        push_exp(1, 16'h48D0, 0, 1, 0, "ignore_inc_start");
        tick();
        cl = 1;
        push_exp(1, 16'h0000, 0, 0, 0, "abort");
        push_exp(2, 16'h0000, 0, 0, 0, "abort_no_done");
        repeat (2) tick();

        // Zero-amount and reserved-op starts complete without shifting
        ld = 1; in = 16'h00FF;
        push_exp(1, 16'h00FF, 0, 0, 0, "ld_00ff");
        tick();
        start = 1; op = 3'd0; amt = 4'd0;
        push_exp(1, 16'h00FF, 0, 0, 1, "amt0_done");
        push_exp(2, 16'h00FF, 0, 0, 0, "amt0_after");
        repeat (2) tick();
        start = 1; op = 3'd6; amt = 4'd3;
        push_exp(1, 16'h00FF, 0, 0, 1, "rsvop_done");
        push_exp(2, 16'h00FF, 0, 0, 0, "rsvop_after");
        repeat (2) tick();

        // Command priority in IDLE
        cl = 1; ld = 1; in = 16'hABCD; start = 1; op = 3'd0; amt = 4'd2;
        push_exp(1, 16'h0000, 0, 0, 0, "cl_over_ld_start");
        push_exp(2, 16'h0000, 0, 0, 0, "cl_over_ld_start2");
        repeat (2) tick();
        ld = 1; in = 16'h003C; start = 1; op = 3'd0; amt = 4'd2;
        push_exp(1, 16'h003C, 0, 0, 0, "ld_over_start");
        push_exp(2, 16'h003C, 0, 0, 0, "ld_over_start2");
        repeat (2) tick();
        start = 1; op = 3'd0; amt = 4'd1; inc = 1;
        push_exp(1, 16'h003C, 0, 1, 0, "start_over_inc");
        push_exp(2, 16'h0078, 0, 0, 1, "shl1_done");
        push_exp(3, 16'h0078, 0, 0, 0, "shl1_after");
        repeat (3) tick();

        // ROL by 2, then SHR by 1 with ir=1
        ld = 1; in = 16'h8001;
        push_exp(1, 16'h8001, 0, 0, 0, "ld_8001b");
        tick();
        start = 1; op = 3'd3; amt = 4'd2;
        push_exp(1, 16'h8001, 0, 1, 0, "rol_s0");
        push_exp(2, 16'h0003, 1, 1, 0, "rol_s1");
        push_exp(3, 16'h0006, 0, 0, 1, "rol_done");
        repeat (3) tick();
        start = 1; op = 3'd1; amt = 4'd1; ir = 1;
        push_exp(1, 16'h0006, 0, 1, 0, "shr_s0");
        push_exp(2, 16'h8003, 0, 0, 1, "shr_done");
        repeat (2) tick();

        // Maximum amount: SHL by 15 with il=1 on 0x0001
        ld = 1; in = 16'h0001;
        push_exp(1, 16'h0001, 0, 0, 0, "ld_0001");
        tick();
        start = 1; op = 3'd0; amt = 4'd15; il = 1;
        push_exp(1,  16'h0001, 0, 1, 0, "shl15_s0");
        push_exp(15, 16'h7FFF, 0, 1, 0, "shl15_s14");
        push_exp(16, 16'hFFFF, 0, 0, 1, "shl15_done");
        push_exp(17, 16'hFFFF, 0, 0, 0, "shl15_after");
        repeat (18) tick();

        repeat (3) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        n_checks++;
        if (act_dones != exp_dones) begin
            n_fail++;
            $display("FAIL done_count: got %0d done cycles, expected %0d", act_dones, exp_dones);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
